// File: rtl/lane_arbiter_if.sv
// Bundle of the request, sensor, gate and status signals of the ramp arbiter.
interface lane_arbiter_if #(
  parameter int CW = 3
);
  logic          req_in;
  logic          req_out;
  logic          sensor_a;
  logic          sensor_b;
  logic          gate_in_open;
  logic          gate_out_open;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          car_done;
  logic          timeout;
  logic          seq_err;

  modport slave (
    input  req_in, req_out, sensor_a, sensor_b,
    output gate_in_open, gate_out_open, count, full, empty,
           car_done, timeout, seq_err
  );

  modport master (
    output req_in, req_out, sensor_a, sensor_b,
    input  gate_in_open, gate_out_open, count, full, empty,
           car_done, timeout, seq_err
  );
endinterface

// File: rtl/lane_arbiter.sv
// Single-lane ramp arbiter: grants one direction at a time, follows the car
// through the a/b sensor pair and keeps a saturating occupancy count.
module lane_arbiter #(
  parameter int CAPACITY = 7,
  parameter int CW       = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  lane_arbiter_if.slave     bus
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, S1, S2, S3} state_t;
  typedef enum logic {DIR_IN, DIR_OUT} dir_t;

  state_t        r_state, w_nstate;
  dir_t          r_dir, w_ndir, r_last_dir, w_nlast;
  logic [TW-1:0] r_timer, w_ntimer;
  logic [CW-1:0] r_count;
  logic          r_gate_in, r_gate_out, r_done, r_to, r_err;
  logic          w_inc, w_dec, w_done, w_to, w_err;
  logic          w_full, w_empty, w_elig_in, w_elig_out;
  logic [1:0]    w_s, w_p1, w_p2, w_p3;

  assign w_full     = (r_count == CW'(CAPACITY));
  assign w_empty    = (r_count == '0);
  assign w_elig_in  = bus.req_in  & ~w_full;
  assign w_elig_out = bus.req_out & ~w_empty;
  assign w_s        = {bus.sensor_a, bus.sensor_b};
  // Sequence patterns of the granted direction; OUT is IN mirrored.
  assign w_p1       = (r_dir == DIR_OUT) ? 2'b01 : 2'b10;
  assign w_p2       = 2'b11;
  assign w_p3       = (r_dir == DIR_OUT) ? 2'b10 : 2'b01;

  // Next-state, arbitration and pulse decode.
  always_comb begin
    w_nstate = r_state;
    w_ndir   = r_dir;
    w_nlast  = r_last_dir;
    w_ntimer = r_timer;
    w_inc    = 1'b0;
    w_dec    = 1'b0;
    w_done   = 1'b0;
    w_to     = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_elig_in && (!w_elig_out || r_last_dir == DIR_OUT)) begin
          w_nstate = WAIT; w_ndir = DIR_IN;  w_nlast = DIR_IN;  w_ntimer = '0;
        end else if (w_elig_out) begin
          w_nstate = WAIT; w_ndir = DIR_OUT; w_nlast = DIR_OUT; w_ntimer = '0;
        end
      end
      WAIT: begin
        if (w_s == 2'b00) begin
          if (r_timer == TW'(TIMEOUT-1)) begin
            w_to = 1'b1; w_nstate = IDLE;
          end else begin
            w_ntimer = r_timer + TW'(1);
          end
        end else if (w_s == w_p1) w_nstate = S1;
        else begin
          w_err = 1'b1; w_nstate = IDLE;
        end
      end
      S1: begin
        if (w_s == w_p2) w_nstate = S2;
        else if (w_s == 2'b00) begin
          w_nstate = WAIT; w_ntimer = '0;   // car backed out before the lane
        end else if (w_s != w_p1) begin
          w_err = 1'b1; w_nstate = IDLE;
        end
      end
      S2: begin
        if (w_s == w_p3) w_nstate = S3;
        else if (w_s == w_p1) w_nstate = S1;
        else if (w_s != w_p2) begin
          w_err = 1'b1; w_nstate = IDLE;
        end
      end
      S3: begin
        if (w_s == 2'b00) begin
          w_done = 1'b1; w_nstate = IDLE;
          w_inc  = (r_dir == DIR_IN);
          w_dec  = (r_dir == DIR_OUT);
        end else if (w_s == w_p2) w_nstate = S2;
        else if (w_s != w_p3) begin
          w_err = 1'b1; w_nstate = IDLE;
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  // State, count, gates and pulses; count saturates regardless of arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_dir      <= DIR_IN;
      r_last_dir <= DIR_OUT;
      r_timer    <= '0;
      r_count    <= '0;
      r_gate_in  <= 1'b0;
      r_gate_out <= 1'b0;
      r_done     <= 1'b0;
      r_to       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_dir      <= w_ndir;
      r_last_dir <= w_nlast;
      r_timer    <= w_ntimer;
      if (w_inc && !w_full)       r_count <= r_count + CW'(1);
      else if (w_dec && !w_empty) r_count <= r_count - CW'(1);
      r_gate_in  <= (w_nstate != IDLE) && (w_ndir == DIR_IN);
      r_gate_out <= (w_nstate != IDLE) && (w_ndir == DIR_OUT);
      r_done     <= w_done;
      r_to       <= w_to;
      r_err      <= w_err;
    end
  end

  assign bus.gate_in_open  = r_gate_in;
  assign bus.gate_out_open = r_gate_out;
  assign bus.count         = r_count;
  assign bus.full          = w_full;
  assign bus.empty         = w_empty;
  assign bus.car_done      = r_done;
  assign bus.timeout       = r_to;
  assign bus.seq_err       = r_err;
endmodule

// File: tb/tb_lane_arbiter.sv
// Directed bench for lane_arbiter: traversals, full lot, tie-break, timeout,
// back-out, sequence error and asynchronous reset mid-traversal.
module tb_lane_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  lane_arbiter_if #(.CW(3)) bus ();

  lane_arbiter #(.CAPACITY(7), .CW(3), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step(input logic [1:0] s);
    {bus.sensor_a, bus.sensor_b} = s;
    tick();
  endtask

  // One complete traversal in the given direction (0 = IN, 1 = OUT).
  task automatic trav(input bit out_dir);
    if (out_dir) bus.req_out = 1'b1; else bus.req_in = 1'b1;
    tick();
    bus.req_in = 1'b0; bus.req_out = 1'b0;
    if (out_dir) begin step(2'b01); step(2'b11); step(2'b10); step(2'b00); end
    else         begin step(2'b10); step(2'b11); step(2'b01); step(2'b00); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_in = 0; bus.req_out = 0; bus.sensor_a = 0; bus.sensor_b = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.gate_in_open !== 1'b0 || bus.gate_out_open !== 1'b0) begin n_bad++; $display("FAIL reset_gates: got %b%b want 00", bus.gate_in_open, bus.gate_out_open); end
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_bad++; $display("FAIL reset_flags: empty=%b full=%b want 1 0", bus.empty, bus.full); end
    n_cmp++; if ({bus.car_done, bus.timeout, bus.seq_err} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {bus.car_done, bus.timeout, bus.seq_err}); end
  endtask

  task automatic test_basic_in();
    bus.req_in = 1'b1;
    tick();
    bus.req_in = 1'b0;
    n_cmp++; if (bus.gate_in_open !== 1'b1) begin n_bad++; $display("FAIL basic_grant: gate_in got %b want 1", bus.gate_in_open); end
    n_cmp++; if (bus.gate_out_open !== 1'b0) begin n_bad++; $display("FAIL basic_other_gate: got %b want 0", bus.gate_out_open); end
    step(2'b10); step(2'b11); step(2'b01);
    n_cmp++; if (bus.car_done !== 1'b0 || bus.gate_in_open !== 1'b1) begin n_bad++; $display("FAIL basic_s3: done=%b gate=%b want 0 1", bus.car_done, bus.gate_in_open); end
    step(2'b00);
    n_cmp++; if (bus.car_done !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", bus.car_done); end
    n_cmp++; if (bus.count !== 3'd1 || bus.empty !== 1'b0) begin n_bad++; $display("FAIL basic_count: count=%0d empty=%b want 1 0", bus.count, bus.empty); end
    n_cmp++; if (bus.gate_in_open !== 1'b0) begin n_bad++; $display("FAIL basic_gate_close: got %b want 0", bus.gate_in_open); end
    tick();
    n_cmp++; if (bus.car_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", bus.car_done); end
  endtask

  task automatic test_full();
    bit opened = 1'b0;
    for (int i = 0; i < 6; i++) trav(1'b0);
    n_cmp++; if (bus.count !== 3'd7 || bus.full !== 1'b1) begin n_bad++; $display("FAIL full_count: count=%0d full=%b want 7 1", bus.count, bus.full); end
    bus.req_in = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (bus.gate_in_open) opened = 1'b1;
    end
    bus.req_in = 1'b0;
    n_cmp++; if (opened !== 1'b0) begin n_bad++; $display("FAIL full_blocked: gate_in opened=%b want 0", opened); end
    n_cmp++; if (bus.count !== 3'd7) begin n_bad++; $display("FAIL full_hold: count=%0d want 7", bus.count); end
  endtask

  task automatic test_tie();
    for (int i = 0; i < 5; i++) trav(1'b1);
    trav(1'b0);
    n_cmp++; if (bus.count !== 3'd3) begin n_bad++; $display("FAIL tie_setup: count=%0d want 3", bus.count); end
    bus.req_in = 1'b1; bus.req_out = 1'b1;
    tick();
    n_cmp++; if (bus.gate_out_open !== 1'b1 || bus.gate_in_open !== 1'b0) begin n_bad++; $display("FAIL tie_first: out=%b in=%b want 1 0", bus.gate_out_open, bus.gate_in_open); end
    step(2'b01); step(2'b11); step(2'b10); step(2'b00);
    n_cmp++; if (bus.count !== 3'd2 || bus.car_done !== 1'b1) begin n_bad++; $display("FAIL tie_out_done: count=%0d done=%b want 2 1", bus.count, bus.car_done); end
    tick();
    bus.req_in = 1'b0; bus.req_out = 1'b0;
    n_cmp++; if (bus.gate_in_open !== 1'b1 || bus.gate_out_open !== 1'b0) begin n_bad++; $display("FAIL tie_second: in=%b out=%b want 1 0", bus.gate_in_open, bus.gate_out_open); end
    step(2'b10); step(2'b11); step(2'b01); step(2'b00);
    n_cmp++; if (bus.count !== 3'd3) begin n_bad++; $display("FAIL tie_in_done: count=%0d want 3", bus.count); end
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    bus.req_in = 1'b1;
    tick();
    bus.req_in = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(2'b00);
      if (bus.timeout || !bus.gate_in_open) early = 1'b1;
    end
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL timeout_early: premature expiry=%b want 0", early); end
    step(2'b00);
    n_cmp++; if (bus.timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_pulse: got %b want 1", bus.timeout); end
    n_cmp++; if (bus.gate_in_open !== 1'b0 || bus.count !== 3'd3) begin n_bad++; $display("FAIL timeout_state: gate=%b count=%0d want 0 3", bus.gate_in_open, bus.count); end
    tick();
    n_cmp++; if (bus.timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_one_cycle: got %b want 0", bus.timeout); end
  endtask

  task automatic test_backout();
    bus.req_in = 1'b1;
    tick();
    bus.req_in = 1'b0;
    step(2'b10); step(2'b11); step(2'b10); step(2'b00);
    n_cmp++; if (bus.car_done !== 1'b0 || bus.seq_err !== 1'b0) begin n_bad++; $display("FAIL backout_pulses: done=%b err=%b want 0 0", bus.car_done, bus.seq_err); end
    n_cmp++; if (bus.gate_in_open !== 1'b1 || bus.count !== 3'd3) begin n_bad++; $display("FAIL backout_wait: gate=%b count=%0d want 1 3", bus.gate_in_open, bus.count); end
    step(2'b10); step(2'b11); step(2'b01); step(2'b00);
    n_cmp++; if (bus.car_done !== 1'b1 || bus.count !== 3'd4) begin n_bad++; $display("FAIL backout_retry: done=%b count=%0d want 1 4", bus.car_done, bus.count); end
  endtask

  task automatic test_seq_err();
    bus.req_in = 1'b1;
    tick();
    bus.req_in = 1'b0;
    step(2'b10); step(2'b01);
    n_cmp++; if (bus.seq_err !== 1'b1) begin n_bad++; $display("FAIL seqerr_pulse: got %b want 1", bus.seq_err); end
    n_cmp++; if (bus.gate_in_open !== 1'b0 || bus.count !== 3'd4) begin n_bad++; $display("FAIL seqerr_state: gate=%b count=%0d want 0 4", bus.gate_in_open, bus.count); end
    step(2'b00);
    n_cmp++; if (bus.seq_err !== 1'b0) begin n_bad++; $display("FAIL seqerr_one_cycle: got %b want 0", bus.seq_err); end
  endtask

  task automatic test_reset_mid();
    bus.req_in = 1'b1;
    tick();
    bus.req_in = 1'b0;
    step(2'b10); step(2'b11);
    n_cmp++; if (bus.gate_in_open !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: gate=%b want 1", bus.gate_in_open); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.gate_in_open !== 1'b0 || bus.gate_out_open !== 1'b0) begin n_bad++; $display("FAIL midrst_gates: got %b%b want 00", bus.gate_in_open, bus.gate_out_open); end
    n_cmp++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_bad++; $display("FAIL midrst_count: count=%0d empty=%b full=%b want 0 1 0", bus.count, bus.empty, bus.full); end
    {bus.sensor_a, bus.sensor_b} = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if ({bus.car_done, bus.timeout, bus.seq_err, bus.gate_in_open} !== 4'b0000) begin n_bad++; $display("FAIL midrst_after: got %b want 0000", {bus.car_done, bus.timeout, bus.seq_err, bus.gate_in_open}); end
  endtask

  initial begin
    test_reset();
    test_basic_in();
    test_full();
    test_tie();
    test_timeout();
    test_backout();
    test_seq_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
